// File: rtl/pellet_eater.sv
// pellet_eater: per-frame tile eater that clears pellets from the maze map and keeps score, pellet count and power timer.
module pellet_eater #(
  parameter int PELLET_COUNT = 244,
  parameter int POWER_FRAMES = 360
) (
  input  logic        vga_pix_clk,
  input  logic        rst,
  input  logic        frame_stb,
  input  logic [8:0]  x_pac,
  input  logic [8:0]  y_pac,
  output logic [10:0] map_rd_addr,
  input  logic [3:0]  map_rd_data,
  output logic        map_we,
  output logic [10:0] map_wr_addr,
  output logic [3:0]  map_wr_data,
  output logic [15:0] score,
  output logic [8:0]  pellets_left,
  output logic        power_active,
  output logic [8:0]  power_frames,
  output logic        eat_pellet,
  output logic        eat_power,
  output logic        level_done
);
  typedef enum logic [1:0] {IDLE, RD, CHK, WR} state_t;
  state_t state, state_n;
  logic [10:0] addr_q;
  logic take, edible;
  assign take = frame_stb && x_pac[2:0] == 3'd0 && y_pac[2:0] == 3'd0 && !x_pac[8] && y_pac[8:3] <= 6'd35;
  assign edible = map_rd_data == 4'b1001 || map_rd_data == 4'b1010;
  assign map_rd_addr = addr_q;
  assign power_active = power_frames != 9'd0;
  // Adds to the tens digit with per-digit carry; an overflow past the thousands digit saturates.
  function automatic logic [15:0] bcd_add(input logic [15:0] s, input logic [3:0] inc);
    logic [4:0] d1, d2, d3;
    logic c1, c2;
    d1 = {1'b0, s[7:4]} + {1'b0, inc};
    c1 = d1 > 5'd9;
    d1 = c1 ? d1 - 5'd10 : d1;
    d2 = {1'b0, s[11:8]} + {4'd0, c1};
    c2 = d2 > 5'd9;
    d2 = c2 ? d2 - 5'd10 : d2;
    d3 = {1'b0, s[15:12]} + {4'd0, c2};
    return d3 > 5'd9 ? 16'h9999 : {d3[3:0], d2[3:0], d1[3:0], s[3:0]};
  endfunction
  always_ff @(posedge vga_pix_clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (take ? RD : IDLE) :
              state == RD ? CHK :
              (state == CHK && edible) ? WR : IDLE;
  end
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      addr_q       <= 11'd0;
      map_we       <= 1'b0;
      map_wr_addr  <= 11'd0;
      map_wr_data  <= 4'd0;
      eat_pellet   <= 1'b0;
      eat_power    <= 1'b0;
      score        <= 16'h0000;
      pellets_left <= PELLET_COUNT[8:0];
      power_frames <= 9'd0;
      level_done   <= 1'b0;
    end else begin
      if (state == IDLE && take) addr_q <= {y_pac[8:3], x_pac[7:3]};
      map_we     <= state == CHK && edible;
      eat_pellet <= state == CHK && map_rd_data == 4'b1001;
      eat_power  <= state == CHK && map_rd_data == 4'b1010;
      if (state == CHK && edible) begin
        map_wr_addr <= addr_q;
        map_wr_data <= 4'b1000;
      end
      // eat_power is only high in WR, so it doubles as the eaten-kind flag there.
      if (state == WR) begin
        score        <= bcd_add(score, eat_power ? 4'd5 : 4'd1);
        pellets_left <= pellets_left == 9'd0 ? 9'd0 : pellets_left - 9'd1;
        if (pellets_left == 9'd1) level_done <= 1'b1;
      end
      power_frames <= (state == WR && eat_power) ? POWER_FRAMES[8:0] :
                      (frame_stb && power_frames != 9'd0) ? power_frames - 9'd1 : power_frames;
    end
  end
endmodule

// File: tb/tb_pellet_eater.sv
// tb_pellet_eater: scoreboard bench; eat stimulus queues expected writes and counters, a monitor checks each map write.
module tb_pellet_eater;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, stb = 1'b0, stb2 = 1'b0;
  logic [8:0] x = 9'd0, y = 9'd0, x2 = 9'd0, y2 = 9'd0;
  logic [10:0] rd_addr, wr_addr, rd_addr2, wr_addr2;
  logic [3:0] rd_data, wr_data, rd_data2, wr_data2;
  logic we, we2, active, active2, eatp, eatw, eatp2, eatw2, done, done2;
  logic [15:0] score, score2;
  logic [8:0] left, left2, pf, pf2;
  logic [3:0] ram [2048];
  logic [3:0] ram2 [2048];
  logic poke = 1'b0;
  logic [10:0] poke_addr = 11'd0;
  logic [3:0] poke_data = 4'd0;
  pellet_eater dut (
    .vga_pix_clk(clk), .rst(rst), .frame_stb(stb), .x_pac(x), .y_pac(y),
    .map_rd_addr(rd_addr), .map_rd_data(rd_data), .map_we(we), .map_wr_addr(wr_addr),
    .map_wr_data(wr_data), .score(score), .pellets_left(left), .power_active(active),
    .power_frames(pf), .eat_pellet(eatp), .eat_power(eatw), .level_done(done));
  pellet_eater #(.PELLET_COUNT(2)) dut2 (
    .vga_pix_clk(clk), .rst(rst), .frame_stb(stb2), .x_pac(x2), .y_pac(y2),
    .map_rd_addr(rd_addr2), .map_rd_data(rd_data2), .map_we(we2), .map_wr_addr(wr_addr2),
    .map_wr_data(wr_data2), .score(score2), .pellets_left(left2), .power_active(active2),
    .power_frames(pf2), .eat_pellet(eatp2), .eat_power(eatw2), .level_done(done2));
  always @(posedge clk) begin
    if (poke) begin
      ram[poke_addr]  <= poke_data;
      ram2[poke_addr] <= poke_data;
    end
    if (we) ram[wr_addr] <= wr_data;
    if (we2) ram2[wr_addr2] <= wr_data2;
    rd_data  <= ram[rd_addr];
    rd_data2 <= ram2[rd_addr2];
  end
  typedef struct {int addr; bit power; int score; int left; int pf; bit done;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int m_score, m_left, m_pf;
  bit m_done;
  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int to_bcd(int d);
    return (d / 1000) * 4096 + (d / 100 % 10) * 256 + (d / 10 % 10) * 16 + d % 10;
  endfunction
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_reset();
    m_score = 0; m_left = 244; m_pf = 0; m_done = 0;
  endtask
  task automatic put(int a, int t);
    poke = 1'b1; poke_addr = a[10:0]; poke_data = t[3:0];
    tick(1);
    poke = 1'b0;
  endtask
  task automatic frame(int xx, int yy);
    x = xx[8:0]; y = yy[8:0]; stb = 1'b1;
    if (m_pf > 0) m_pf--;
    tick(1);
    stb = 1'b0;
    tick(5);
  endtask
  task automatic eat(int xx, int yy, bit pw);
    exp_t e;
    int a;
    a = (yy / 8) * 32 + xx / 8;
    put(a, pw ? 10 : 9);
    m_score = (m_score + (pw ? 50 : 10) > 9999) ? 9999 : m_score + (pw ? 50 : 10);
    if (m_left == 1) m_done = 1;
    if (m_left > 0) m_left--;
    e.addr = a; e.power = pw; e.score = m_score; e.left = m_left;
    e.pf = pw ? 360 : (m_pf > 0 ? m_pf - 1 : 0); e.done = m_done;
    q.push_back(e);
    frame(xx, yy);
    if (pw) m_pf = 360;
  endtask
  task automatic eat2(int xx, int yy);
    x2 = xx[8:0]; y2 = yy[8:0]; stb2 = 1'b1;
    tick(1);
    stb2 = 1'b0;
    tick(3);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (we) begin
        if (q.size() == 0) check("unexpected_we", we, 0);
        else begin
          e = q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, 8);
          check("eat_pellet", eatp, !e.power);
          check("eat_power", eatw, e.power);
          @(negedge clk);
          check("we_one_cycle", we, 0);
          check("score", score, to_bcd(e.score));
          check("pellets_left", left, e.left);
          check("power_frames", pf, e.pf);
          check("power_active", active, e.pf != 0);
          check("level_done", done, e.done);
        end
      end
    end
  end
  initial begin
    @(negedge clk);
    tick(2);
    rst = 1'b0;
    model_reset();
    check("rst_score", score, 0);
    check("rst_left", left, 244);
    check("rst_pf", pf, 0);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_we", we, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_left2", left2, 2);
    eat(8, 32, 0);
    check("rd_addr_129", rd_addr, 129);
    eat(16, 64, 1);
    repeat (355) frame(9, 32);
    check("pf_at_5", pf, 5);
    eat(24, 64, 1);
    check("pf_reload", pf, 360);
    repeat (360) frame(9, 32);
    check("pf_expired", pf, 0);
    check("active_expired", active, 0);
    frame(8, 32);
    put(161, 0);
    frame(8, 40);
    put(130, 9);
    frame(17, 32);
    frame(16, 33);
    put(1185, 9);
    frame(8, 296);
    check("offmap_rd_addr", rd_addr, 161);
    check("noeat_score", score, to_bcd(m_score));
    check("noeat_left", left, m_left);
    check("unaligned_tile_kept", ram[130], 9);
    check("offmap_tile_kept", ram[1185], 9);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 1001; i++) begin
      eat(8, 32, 0);
      if (i == 9) check("bcd_0090", score, 16'h0090);
      if (i == 10) check("bcd_carry", score, 16'h0100);
      if (i == 999) check("bcd_9990", score, 16'h9990);
      if (i == 1000) check("bcd_sat", score, 16'h9999);
      if (i == 1001) check("bcd_sat_hold", score, 16'h9999);
    end
    put(129, 9);
    x = 9'd8; y = 9'd32; stb = 1'b1;
    tick(1);
    stb = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    check("rstchk_we", we, 0);
    check("rstchk_eatp", eatp, 0);
    check("rstchk_score", score, 0);
    check("rstchk_left", left, 244);
    check("rstchk_done", done, 0);
    check("rstchk_rd_addr", rd_addr, 0);
    check("rstchk_wr_addr", wr_addr, 0);
    check("rstchk_wr_data", wr_data, 0);
    rst = 1'b0;
    model_reset();
    tick(3);
    check("rstchk_tile_kept", ram[129], 9);
    put(129, 9);
    put(130, 9);
    put(131, 9);
    eat2(8, 32);
    check("p2_left_1", left2, 1);
    check("p2_done_0", done2, 0);
    x2 = 9'd16; y2 = 9'd32; stb2 = 1'b1;
    tick(1);
    stb2 = 1'b0;
    tick(2);
    check("p2_done_before_t4", done2, 0);
    tick(1);
    check("p2_left_0", left2, 0);
    check("p2_done_1", done2, 1);
    tick(2);
    eat2(24, 32);
    check("p2_score_30", score2, 16'h0030);
    check("p2_left_sat", left2, 0);
    check("p2_done_sticky", done2, 1);
    tick(2);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
